// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller for the CoreUART x16 baud generator: times 8 bit periods of a 0x55 sync
// frame on rx and derives baud_val/baud_fraction, or loads them directly from software.
module uart_autobaud_ctrl #(
   parameter bit            BAUD_VAL_FRCTN_EN = 1'b0,
   parameter logic [12:0]   DEFAULT_BAUD_VAL  = 13'd1,
   parameter int unsigned   IDLE_CYCLES       = 64,
   parameter int unsigned   MAX_CNT           = 32'd1 << 20
) (
   input  logic        clk,
   input  logic        aresetn,
   input  logic        rx,
   input  logic        start,
   input  logic        cfg_wr,
   input  logic [12:0] cfg_baud_val,
   input  logic [2:0]  cfg_fraction,
   output logic [12:0] baud_val,
   output logic [2:0]  baud_fraction,
   output logic        busy,
   output logic        cfg_update,
   output logic        done,
   output logic        err
);

   localparam int unsigned CNT_W     = 21;
   localparam int unsigned IDLE_W    = $clog2(IDLE_CYCLES + 1);
   localparam int unsigned ROUND_ADD = BAUD_VAL_FRCTN_EN ? 8 : 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_WAIT_START,
      S_MEASURE,
      S_CALC
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          edge_cnt_q, edge_cnt_d;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [12:0]         baud_val_q, baud_val_d;
   logic [2:0]          baud_fraction_q, baud_fraction_d;
   logic                busy_q, busy_d;
   logic                cfg_update_q, cfg_update_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                rx_meta_q, rx_meta_d;
   logic                rx_sync_q, rx_sync_d;
   logic                rx_prev_q, rx_prev_d;

   logic                fall_c;
   logic [CNT_W-1:0]    sum_c;
   logic [13:0]         s_hi_c;
   logic [13:0]         bv_c;
   logic [4:0]          calc_unused_c;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         edge_cnt_q      <= '0;
         idle_cnt_q      <= '0;
         baud_val_q      <= DEFAULT_BAUD_VAL;
         baud_fraction_q <= '0;
         busy_q          <= 1'b0;
         cfg_update_q    <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
         rx_meta_q       <= 1'b1;
         rx_sync_q       <= 1'b1;
         rx_prev_q       <= 1'b1;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         edge_cnt_q      <= edge_cnt_d;
         idle_cnt_q      <= idle_cnt_d;
         baud_val_q      <= baud_val_d;
         baud_fraction_q <= baud_fraction_d;
         busy_q          <= busy_d;
         cfg_update_q    <= cfg_update_d;
         done_q          <= done_d;
         err_q           <= err_d;
         rx_meta_q       <= rx_meta_d;
         rx_sync_q       <= rx_sync_d;
         rx_prev_q       <= rx_prev_d;
      end
   end

   // Next-state, measurement counters and output register loads.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      edge_cnt_d      = edge_cnt_q;
      idle_cnt_d      = idle_cnt_q;
      baud_val_d      = baud_val_q;
      baud_fraction_d = baud_fraction_q;
      cfg_update_d    = 1'b0;
      done_d          = 1'b0;
      err_d           = 1'b0;
      rx_meta_d       = rx;
      rx_sync_d       = rx_meta_q;
      rx_prev_d       = rx_sync_q;

      fall_c        = rx_prev_q & ~rx_sync_q;
      // Rounding offset added before dividing N8 by 128 (8 bits x 16 oversampling).
      sum_c         = cnt_q + CNT_W'(ROUND_ADD);
      s_hi_c        = sum_c[20:7];
      bv_c          = s_hi_c - 14'd1;
      calc_unused_c = {bv_c[13], sum_c[3:0]};

      if (cfg_wr) begin
         baud_val_d      = cfg_baud_val;
         baud_fraction_d = BAUD_VAL_FRCTN_EN ? cfg_fraction : 3'b000;
         cfg_update_d    = 1'b1;
         state_d         = S_IDLE;
         cnt_d           = '0;
         edge_cnt_d      = '0;
         idle_cnt_d      = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_WAIT_IDLE;
                  idle_cnt_d = '0;
               end
            end
            S_WAIT_IDLE: begin
               if (idle_cnt_q == IDLE_W'(IDLE_CYCLES)) begin
                  state_d = S_WAIT_START;
               end else if (!rx_sync_q) begin
                  idle_cnt_d = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + IDLE_W'(1);
               end
            end
            S_WAIT_START: begin
               if (fall_c) begin
                  state_d    = S_MEASURE;
                  cnt_d      = CNT_W'(1);
                  edge_cnt_d = '0;
               end
            end
            S_MEASURE: begin
               if (fall_c && edge_cnt_q == 2'd3) begin
                  state_d = S_CALC;
               end else if (cnt_q == CNT_W'(MAX_CNT)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (fall_c) begin
                     edge_cnt_d = edge_cnt_q + 2'd1;
                  end
               end
            end
            S_CALC: begin
               state_d = S_IDLE;
               if (s_hi_c < 14'd2 || s_hi_c > 14'd8192) begin
                  err_d = 1'b1;
               end else begin
                  baud_val_d      = bv_c[12:0];
                  baud_fraction_d = BAUD_VAL_FRCTN_EN ? sum_c[6:4] : 3'b000;
                  cfg_update_d    = 1'b1;
                  done_d          = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   assign baud_val      = baud_val_q;
   assign baud_fraction = baud_fraction_q;
   assign busy          = busy_q;
   assign cfg_update    = cfg_update_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule
